// File: rtl/spi_master_sequencer.sv
// SPI mode-0 (CPOL=0, CPHA=0, MSB first) master sequencer driving an external
// parallel-load shift register; an output-consistency checker follows the top.
module spi_master_sequencer #(
    parameter int WIDTH = 8,
    parameter int HALF  = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             miso,
    input  logic [WIDTH-1:0] sr_parallel_out,
    output logic [1:0]       sr_mode,
    output logic             sr_en,
    output logic             sr_serial_in,
    output logic             mosi,
    output logic             sclk,
    output logic             cs_n,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rx_data
);

    localparam int BW = $clog2(WIDTH + 1);
    localparam int HW = (HALF > 1) ? $clog2(HALF) : 1;

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_PLOAD = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SETUP = 3'd2,
        S_HIGH  = 3'd3,
        S_LOW   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [HW-1:0]   half_cnt_r;
    logic [BW-1:0]   bit_cnt_r;
    logic [BW-1:0]   bit_inc_s;
    logic            miso_q_r;
    logic            half_last_s;
    logic            first_high_s;
    logic            enter_low_s;
    logic [1:0]      mode_s;
    logic            en_s;
    logic            sin_s;
    logic            sclk_s;
    logic            cs_n_s;
    logic            busy_s;
    logic            done_s;

    assign half_last_s  = (half_cnt_r == HW'(HALF - 1));
    assign first_high_s = (state_r == S_HIGH) && (half_cnt_r == {HW{1'b0}});
    assign enter_low_s  = (state_r == S_HIGH) && half_last_s;
    assign bit_inc_s    = bit_cnt_r + BW'(1);

    // Next-state selection; timed phases each last HALF clocks
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) state_s = S_LOAD;
                else       state_s = S_IDLE;
            end
            S_LOAD: state_s = S_SETUP;
            S_SETUP: begin
                if (half_last_s) state_s = S_HIGH;
                else             state_s = S_SETUP;
            end
            S_HIGH: begin
                if (half_last_s) state_s = S_LOW;
                else             state_s = S_HIGH;
            end
            S_LOW: begin
                if (half_last_s) begin
                    if (bit_inc_s < BW'(WIDTH)) state_s = S_HIGH;
                    else                        state_s = S_DONE;
                end else begin
                    state_s = S_LOW;
                end
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Output values for the coming cycle, derived from the state being entered
    always_comb begin
        mode_s = MODE_HOLD;
        en_s   = 1'b0;
        sin_s  = 1'b0;
        if (state_s == S_LOAD) begin
            mode_s = MODE_PLOAD;
            en_s   = 1'b1;
        end else if (enter_low_s) begin
            // With HALF=1 the capture edge and the shift-issue edge coincide
            mode_s = MODE_LEFT;
            en_s   = 1'b1;
            sin_s  = first_high_s ? miso : miso_q_r;
        end else begin
            mode_s = MODE_HOLD;
            en_s   = 1'b0;
            sin_s  = 1'b0;
        end
        sclk_s = (state_s == S_HIGH);
        cs_n_s = !((state_s == S_SETUP) || (state_s == S_HIGH) || (state_s == S_LOW));
        busy_s = (state_s != S_IDLE);
        done_s = (state_s == S_DONE);
    end

    // State register and phase/bit counters
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r    <= S_IDLE;
            half_cnt_r <= {HW{1'b0}};
            bit_cnt_r  <= {BW{1'b0}};
            miso_q_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            if ((state_s != state_r) || (state_r == S_IDLE)) begin
                half_cnt_r <= {HW{1'b0}};
            end else begin
                half_cnt_r <= half_cnt_r + HW'(1);
            end
            if (state_r == S_LOAD) begin
                bit_cnt_r <= {BW{1'b0}};
            end else if ((state_r == S_LOW) && half_last_s) begin
                bit_cnt_r <= bit_inc_s;
            end else begin
                bit_cnt_r <= bit_cnt_r;
            end
            if (first_high_s) begin
                miso_q_r <= miso;
            end else begin
                miso_q_r <= miso_q_r;
            end
        end
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sr_mode      <= MODE_HOLD;
            sr_en        <= 1'b0;
            sr_serial_in <= 1'b0;
            sclk         <= 1'b0;
            cs_n         <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            rx_data      <= {WIDTH{1'b0}};
        end else begin
            sr_mode      <= mode_s;
            sr_en        <= en_s;
            sr_serial_in <= sin_s;
            sclk         <= sclk_s;
            cs_n         <= cs_n_s;
            busy         <= busy_s;
            done         <= done_s;
            // The last shift may land on the edge entering DONE, so capture on leaving it
            if (state_r == S_DONE) begin
                rx_data <= sr_parallel_out;
            end else begin
                rx_data <= rx_data;
            end
        end
    end

    assign mosi = cs_n ? 1'b0 : sr_parallel_out[WIDTH-1];

    spi_master_sequencer_chk #(
        .WIDTH (WIDTH)
    ) u_chk (
        .clk     (clk),
        .reset_n (reset_n),
        .tx_data (tx_data),
        .sr_mode (sr_mode),
        .sr_en   (sr_en),
        .mosi    (mosi),
        .sclk    (sclk),
        .cs_n    (cs_n),
        .busy    (busy),
        .done    (done)
    );

endmodule

// Protocol checker: enable/mode pairing, framing, and MOSI tracking of the loaded word.
module spi_master_sequencer_chk #(
    parameter int WIDTH = 8
) (
    input logic             clk,
    input logic             reset_n,
    input logic [WIDTH-1:0] tx_data,
    input logic [1:0]       sr_mode,
    input logic             sr_en,
    input logic             mosi,
    input logic             sclk,
    input logic             cs_n,
    input logic             busy,
    input logic             done
);

    logic [WIDTH-1:0] tx_sh_r;

    // Shadow of the word being shifted out, mirroring the external register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_sh_r <= {WIDTH{1'b0}};
        end else if (sr_en && (sr_mode == 2'b11)) begin
            tx_sh_r <= tx_data;
        end else if (sr_en && (sr_mode == 2'b10)) begin
            tx_sh_r <= {tx_sh_r[WIDTH-2:0], 1'b0};
        end else begin
            tx_sh_r <= tx_sh_r;
        end
    end

    a_en_mode: assert property (@(posedge clk) disable iff (!reset_n)
        sr_en |-> ((sr_mode == 2'b11) || (sr_mode == 2'b10)));
    a_hold: assert property (@(posedge clk) disable iff (!reset_n)
        !sr_en |-> (sr_mode == 2'b00));
    a_sclk_cs: assert property (@(posedge clk) disable iff (!reset_n)
        sclk |-> !cs_n);
    a_done: assert property (@(posedge clk) disable iff (!reset_n)
        done |-> (busy && cs_n && !sclk));
    a_mosi: assert property (@(posedge clk) disable iff (!reset_n)
        (!cs_n && sclk) |-> (mosi == tx_sh_r[WIDTH-1]));

endmodule
